// File: rtl/alien_bomb_dropper.sv
// Alien bomb pool: accepts fire requests, drops bombs on a motion tick, detects player hits,
// tracks lives and drives the bomb sprite pixel. Optional macro: ALIEN_BOMB_IFRAME_EN (post-hit grace).
module alien_bomb_dropper #(
    parameter int NUM_BOMBS     = 4,
    parameter int TICK_DIV      = 250000,
    parameter int BOMB_STEP     = 2,
    parameter int SCREEN_BOTTOM = 480,
    parameter int PLAYER_ROW    = 440,
    parameter int START_LIVES   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    input  logic        fire_req,
    input  logic [11:0] fire_row,
    input  logic [11:0] fire_column,
    input  logic [11:0] player_column,
    output logic        fire_ack,
    output logic        bomb_active,
    output logic [3:0]  bomb_output,
    output logic        player_hit,
    output logic [1:0]  lives,
    output logic        game_over
);

    localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [11:0]       STEP      = 12'(BOMB_STEP);
    localparam logic [12:0]       BOTTOM    = 13'(SCREEN_BOTTOM);
    localparam logic [12:0]       P_ROW     = 13'(PLAYER_ROW);

    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [NUM_BOMBS-1:0] valid_q, valid_d;
    logic [11:0]          row_q [NUM_BOMBS];
    logic [11:0]          row_d [NUM_BOMBS];
    logic [11:0]          col_q [NUM_BOMBS];
    logic [11:0]          col_d [NUM_BOMBS];
    logic [11:0]          next_row [NUM_BOMBS];
    logic [NUM_BOMBS-1:0] hit_vec, retire_vec, load_sel;
    logic                 free_found;
    logic                 any_hit, counted_hit, grace_idle, ending, accept;
    logic                 fire_ack_q, fire_ack_d;
    logic                 player_hit_q, player_hit_d;
    logic                 game_over_q, game_over_d;
    logic [1:0]           lives_q, lives_d;
    logic                 pix_hit;

    // Bomb box rows r+1..r+4, cols c+1..c+2 against player box rows P+1..P+20, cols pc+1..pc+30.
    function automatic logic overlaps_player(input logic [11:0] r, input logic [11:0] c,
                                             input logic [11:0] pc);
        logic [12:0] r13, c13, pc13;
        r13  = {1'b0, r};
        c13  = {1'b0, c};
        pc13 = {1'b0, pc};
        return (r13 <= P_ROW + 13'd19) && (P_ROW <= r13 + 13'd3) &&
               (c13 <= pc13 + 13'd29) && (pc13 <= c13 + 13'd1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_BOMBS; i++) begin
            next_row[i]   = row_q[i] + STEP;
            hit_vec[i]    = valid_q[i] && overlaps_player(next_row[i], col_q[i], player_column);
            retire_vec[i] = valid_q[i] && ({1'b0, next_row[i]} >= BOTTOM);
        end
    end

    always_comb begin
        load_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (!valid_q[i] && !free_found) begin
                load_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    // Handshake: the requester holds fire_req until fire_ack. A request is accepted when a slot is
    // free at the start of the cycle; fire_ack pulses the cycle after and blocks a second accept
    // while the requester is still dropping fire_req.
    always_comb begin
        tick        = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CNT_W'(1);
        any_hit     = tick && (|hit_vec) && !game_over_q;
        counted_hit = any_hit && grace_idle;
        ending      = counted_hit && (lives_q == 2'd1);
        accept      = fire_req && !game_over_q && free_found && !fire_ack_q && !ending;

        fire_ack_d   = accept;
        player_hit_d = counted_hit;
        lives_d      = lives_q;
        game_over_d  = game_over_q;
        if (counted_hit) begin
            lives_d = lives_q - 2'd1;
            if (ending) begin
                game_over_d = 1'b1;
            end
        end
    end

    // Collision outranks the bottom retire; both only act on slots valid before this cycle.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            row_d[i] = row_q[i];
            col_d[i] = col_q[i];
            if (tick && valid_q[i]) begin
                if (hit_vec[i] || retire_vec[i]) begin
                    valid_d[i] = 1'b0;
                end else begin
                    row_d[i] = next_row[i];
                end
            end
            if (accept && load_sel[i]) begin
                valid_d[i] = 1'b1;
                row_d[i]   = fire_row;
                col_d[i]   = fire_column;
            end
            if (ending) begin
                valid_d[i] = 1'b0;
            end
        end
    end

`ifdef ALIEN_BOMB_IFRAME_EN
    logic [5:0] grace_q, grace_d;

    always_comb begin
        grace_d = grace_q;
        if (counted_hit) begin
            grace_d = 6'd32;
        end else if (tick && (grace_q != 6'd0)) begin
            grace_d = grace_q - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grace_q <= '0;
        end else begin
            grace_q <= grace_d;
        end
    end

    assign grace_idle = (grace_q == 6'd0);
`else
    assign grace_idle = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q   <= '0;
            valid_q      <= '0;
            fire_ack_q   <= 1'b0;
            player_hit_q <= 1'b0;
            lives_q      <= 2'(START_LIVES);
            game_over_q  <= 1'b0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            valid_q      <= valid_d;
            fire_ack_q   <= fire_ack_d;
            player_hit_q <= player_hit_d;
            lives_q      <= lives_d;
            game_over_q  <= game_over_d;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                row_q[i] <= row_d[i];
                col_q[i] <= col_d[i];
            end
        end
    end

    // Sprite test uses 13-bit sums so rows/columns near 4095 do not wrap.
    always_comb begin
        pix_hit = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (valid_q[i] &&
                (pixel_row > row_q[i]) && ({1'b0, pixel_row} < {1'b0, row_q[i]} + 13'd5) &&
                (pixel_column > col_q[i]) && ({1'b0, pixel_column} < {1'b0, col_q[i]} + 13'd3)) begin
                pix_hit = 1'b1;
            end
        end
    end

    assign bomb_active = pix_hit;
    assign bomb_output = {4{pix_hit}};
    assign fire_ack    = fire_ack_q;
    assign player_hit  = player_hit_q;
    assign lives       = lives_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_alien_bomb_dropper.sv
// Directed bench for alien_bomb_dropper with TICK_DIV=4; tracks the tick phase with its own counter.
module tb_alien_bomb_dropper;

  logic        clk;
  logic        rst;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic        fire_req;
  logic [11:0] fire_row;
  logic [11:0] fire_column;
  logic [11:0] player_column;
  logic        fire_ack;
  logic        bomb_active;
  logic [3:0]  bomb_output;
  logic        player_hit;
  logic [1:0]  lives;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cnt   = 0;
  int tb_ticks = 0;
  int hit_cnt  = 0;

  alien_bomb_dropper #(
    .NUM_BOMBS(4), .TICK_DIV(4), .BOMB_STEP(2), .SCREEN_BOTTOM(480),
    .PLAYER_ROW(440), .START_LIVES(3)
  ) dut (
    .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .fire_req(fire_req), .fire_row(fire_row), .fire_column(fire_column),
    .player_column(player_column), .fire_ack(fire_ack), .bomb_active(bomb_active),
    .bomb_output(bomb_output), .player_hit(player_hit), .lives(lives), .game_over(game_over)
  );

  // clock / reset block and independent tick-phase model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_cnt <= 0;
    end else if (tb_cnt == 3) begin
      tb_cnt   <= 0;
      tb_ticks <= tb_ticks + 1;
    end else begin
      tb_cnt <= tb_cnt + 1;
    end
  end

  always @(negedge clk) if (player_hit) hit_cnt <= hit_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst      = 1'b0;
    fire_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fire(input logic [11:0] r, input logic [11:0] c);
    int guard;
    guard       = 0;
    fire_row    = r;
    fire_column = c;
    fire_req    = 1'b1;
    @(negedge clk);
    while (!fire_ack && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    fire_req = 1'b0;
    check_val("fire_ack_seen", fire_ack, 1);
  endtask

  task automatic wait_tick(input int target);
    int guard;
    guard = 0;
    while (tb_ticks < target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_val("tick_wait", tb_ticks, target);
  endtask

  task automatic probe(input string tag, input int r, input int c, input logic [3:0] exp);
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    #1;
    check_val(tag, bomb_output, exp);
  endtask

  int   t0;
  int   h0;
  int   guard;
  logic early;

  initial begin
    rst = 1'b0; fire_req = 1'b0; fire_row = '0; fire_column = '0;
    pixel_row = '0; pixel_column = '0; player_column = 12'd600;
    repeat (2) @(negedge clk);
    check_val("rst_ack", fire_ack, 0);
    check_val("rst_hit", player_hit, 0);
    check_val("rst_lives", lives, 3);
    check_val("rst_game_over", game_over, 0);
    check_val("rst_active", bomb_active, 0);
    rst = 1'b1;

    // single fire: ack one cycle later, no second ack while request is still high
    fire_row = 12'd100; fire_column = 12'd50; fire_req = 1'b1;
    @(negedge clk);
    check_val("ack_latency", fire_ack, 1);
    t0 = tb_ticks;
    @(negedge clk);
    check_val("ack_no_repeat", fire_ack, 0);
    fire_req = 1'b0;
    wait_tick(t0 + 5);
    probe("pix_112_51", 112, 51, 4'hF);
    probe("pix_112_53", 112, 53, 4'h0);
    probe("pix_110_51", 110, 51, 4'h0);
    probe("pix_115_52", 115, 52, 4'h0);
    probe("pix_114_52", 114, 52, 4'hF);

    // asynchronous reset with two bombs live and fire_ack high
    fire(12'd200, 12'd50);
    probe("pre_rst_active", 202, 51, 4'hF);
    rst = 1'b0;
    #1;
    check_val("midrst_ack", fire_ack, 0);
    check_val("midrst_active", bomb_active, 0);
    check_val("midrst_lives", lives, 3);
    check_val("midrst_game_over", game_over, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // pool full: fifth request waits for the first retire
    fire(12'd470, 12'd10);
    t0 = tb_ticks;
    fire(12'd470, 12'd10);
    fire(12'd470, 12'd10);
    fire(12'd470, 12'd10);
    fire_row = 12'd300; fire_column = 12'd10; fire_req = 1'b1;
    early = 1'b0; guard = 0;
    while (tb_ticks < t0 + 5 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (fire_ack) early = 1'b1;
    end
    check_val("pool_pending", early, 0);
    @(negedge clk);
    check_val("pool_ack_after_retire", fire_ack, 1);
    fire_req = 1'b0;

    // retire boundary at 478 / 480, no hit
    do_reset();
    h0 = hit_cnt;
    fire(12'd476, 12'd10);
    t0 = tb_ticks;
    wait_tick(t0 + 1);
    probe("retire_478_live", 479, 11, 4'hF);
    wait_tick(t0 + 2);
    probe("retire_480_gone", 481, 11, 4'h0);
    check_val("retire_no_hit", hit_cnt - h0, 0);
    check_val("retire_lives", lives, 3);

    // double hit: two bombs aligned to the same tick
    do_reset();
    player_column = 12'd290;
    h0 = hit_cnt;
    guard = 0;
    while (tb_cnt != 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    fire(12'd434, 12'd300);
    fire(12'd434, 12'd300);
    t0 = tb_ticks;
    wait_tick(t0 + 1);
    check_val("dbl_pre_hit", player_hit, 0);
    check_val("dbl_pre_lives", lives, 3);
    wait_tick(t0 + 2);
    check_val("dbl_hit_pulse", player_hit, 1);
    check_val("dbl_lives", lives, 2);
    probe("dbl_slots_freed", 440, 301, 4'h0);
    @(negedge clk);
    check_val("dbl_hit_once", hit_cnt - h0, 1);

`ifdef ALIEN_BOMB_IFRAME_EN
    // grace window: bomb destroyed, no life lost
    fire(12'd434, 12'd300);
    t0 = tb_ticks;
    wait_tick(t0 + 2);
    check_val("grace_no_hit", player_hit, 0);
    check_val("grace_lives", lives, 2);
    probe("grace_bomb_gone", 440, 301, 4'h0);
`else
    fire(12'd434, 12'd300);
    t0 = tb_ticks;
    wait_tick(t0 + 2);
    check_val("hit2_pulse", player_hit, 1);
    check_val("hit2_lives", lives, 1);
    check_val("hit2_game_over", game_over, 0);

    fire(12'd100, 12'd50);
    fire(12'd434, 12'd300);
    t0 = tb_ticks;
    wait_tick(t0 + 1);
    probe("extra_bomb_live", 106, 51, 4'hF);
    wait_tick(t0 + 2);
    check_val("hit3_pulse", player_hit, 1);
    check_val("hit3_lives", lives, 0);
    check_val("hit3_game_over", game_over, 1);
    probe("gameover_cleared", 107, 51, 4'h0);

    early = 1'b0;
    fire_row = 12'd50; fire_column = 12'd50; fire_req = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (fire_ack) early = 1'b1;
    end
    fire_req = 1'b0;
    check_val("gameover_no_ack", early, 0);
    check_val("gameover_sticky", game_over, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
